// File: rtl/router_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_fifo
// Purpose  : Packet-aware synchronous FIFO for a router output channel.
//            Each entry stores {sop_tag, data}. The read side tracks how many
//            words of the current packet remain. It marks the final (parity)
//            word and keeps occupancy, stored-packet count, an almost-full
//            threshold and sticky overflow/underflow error flags.
// Ports    : clock, resetn (sync, active-low), soft_reset (sync flush)
//            write_enb, lfd_state, data_in        - write side
//            read_enb, data_out, data_out_sop,
//            data_out_last, rd_remaining          - read side
//            full, empty, almost_full, count,
//            pkt_count, ovf_err, udf_err          - status
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int LEN_LSB   = 2,
    parameter int LEN_W     = 6,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_out_sop,
    output logic                     data_out_last,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [LEN_W:0]           rd_remaining,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0] c_PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_AF_THRESH = (ADDR_W+1)'(DEPTH - AF_MARGIN);
    localparam logic [LEN_W:0]  c_REM_ONE   = (LEN_W+1)'(1);

    // Entry layout: bit DATA_W is the SOP tag, the rest is the data word.
    logic [DATA_W:0]   r_mem [0:DEPTH-1];

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W:0]   w_rd_entry;
    logic              w_rd_tag;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_pkt_inc;
    logic              w_pkt_dec;
    logic              w_flush;

    assign full        = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                         (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign empty       = (r_wr_ptr == r_rd_ptr);
    assign count       = r_wr_ptr - r_rd_ptr;
    assign almost_full = (count >= c_AF_THRESH);

    assign w_flush     = !resetn || soft_reset;
    assign w_wr_acc    = write_enb && !full;
    assign w_rd_acc    = read_enb && !empty;
    assign w_rd_entry  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign w_rd_tag    = w_rd_entry[DATA_W];
    assign w_hdr_len   = w_rd_entry[LEN_LSB +: LEN_W];
    assign w_pkt_inc   = w_wr_acc && lfd_state;
    assign w_pkt_dec   = w_rd_acc && w_rd_tag;

    // Storage has no reset; stale contents are never visible because the
    // pointers are cleared.
    always_ff @(posedge clock) begin
        if (!w_flush && w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            pkt_count     <= '0;
            rd_remaining  <= '0;
            data_out      <= '0;
            data_out_sop  <= 1'b0;
            data_out_last <= 1'b0;
            ovf_err       <= 1'b0;
            udf_err       <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end

            if (w_rd_acc) begin
                r_rd_ptr      <= r_rd_ptr + c_PTR_ONE;
                data_out      <= w_rd_entry[DATA_W-1:0];
                data_out_sop  <= w_rd_tag;
                // The last word is the one read while exactly one word of
                // the packet was still outstanding.
                data_out_last <= !w_rd_tag && (rd_remaining == c_REM_ONE);
                if (w_rd_tag) begin
                    // The header length covers the payload only; +1 adds parity.
                    rd_remaining <= {1'b0, w_hdr_len} + c_REM_ONE;
                end else if (rd_remaining != '0) begin
                    rd_remaining <= rd_remaining - c_REM_ONE;
                end
            end

            if (w_pkt_inc && !w_pkt_dec) begin
                pkt_count <= pkt_count + c_PTR_ONE;
            end else if (!w_pkt_inc && w_pkt_dec) begin
                pkt_count <= pkt_count - c_PTR_ONE;
            end

            if (write_enb && full) begin
                ovf_err <= 1'b1;
            end
            if (read_enb && empty) begin
                udf_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
